cga_vram_arbiter: RTL

- Shares the single CGA video RAM port between the display fetch path and CPU memory cycles on the ISA bus.
- Display fetches come from the sequencer and always win. The CPU gets one programmable access slot per sequencer period.
- CPU writes are posted through a one-entry buffer. CPU reads stall the bus through bus_rdy until data is captured.
- Sits between the ISA memory decode, the cga sequencer/CRTC address path and the external VRAM pins.

---
 rtl/cga_pkg.sv | 16 +
 rtl/cga_vram_arbiter_if.sv | 32 +++
 rtl/cga_bus_sync.sv | 25 ++
 rtl/cga_vram_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/cga_pkg.sv
// Shared types and constants for the CGA video RAM arbiter.
package cga_pkg;

    localparam int VRAM_AW = 19;
    localparam int CPU_AW  = 15;

    localparam logic [4:0] SEQ_MAX_DEF  = 5'd31;
    localparam logic [4:0] CPU_SLOT_DEF = 5'd17;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } cga_state_e;

endpackage

// File: rtl/cga_vram_arbiter_if.sv
// Bundle of sequencer, ISA and VRAM pin signals seen by the arbiter.
interface cga_vram_arbiter_if;
    import cga_pkg::*;

    logic [4:0]         clk_seq;
    logic               disp_req;
    logic [VRAM_AW-1:0] disp_addr;
    logic               cpu_cs;
    logic [CPU_AW-1:0]  cpu_a;
    logic               cpu_memr_l;
    logic               cpu_memw_l;
    logic [7:0]         cpu_d;
    logic [7:0]         cpu_q;
    logic               bus_rdy;
    logic [VRAM_AW-1:0] ram_a;
    logic               ram_we_l;
    logic [7:0]         ram_dout;
    logic [7:0]         ram_din;

    // Handshake: a synced falling strobe edge with cpu_cs high is a request;
    // bus_rdy low holds the ISA cycle in a wait state until the arbiter can accept or return data.
    modport master (
        output clk_seq, disp_req, disp_addr, cpu_cs, cpu_a, cpu_memr_l, cpu_memw_l, cpu_d, ram_din,
        input  cpu_q, bus_rdy, ram_a, ram_we_l, ram_dout
    );

    modport slave (
        input  clk_seq, disp_req, disp_addr, cpu_cs, cpu_a, cpu_memr_l, cpu_memw_l, cpu_d, ram_din,
        output cpu_q, bus_rdy, ram_a, ram_we_l, ram_dout
    );

endinterface

// File: rtl/cga_bus_sync.sv
// Two-flop synchronizer for an active-low ISA strobe with a falling-edge pulse output.
module cga_bus_sync (
    input  logic clk,
    input  logic reset_l,
    input  logic strobe_l,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= strobe_l;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall = s3 & ~s2;

endmodule

// File: rtl/cga_vram_arbiter.sv
// Shares the CGA VRAM port: display fetches own it except for one CPU slot per sequencer period.
module cga_vram_arbiter
    import cga_pkg::*;
#(
    parameter logic [4:0] SEQ_MAX      = SEQ_MAX_DEF,
    parameter logic [4:0] CPU_SLOT     = CPU_SLOT_DEF,
    parameter int         RAM_LATENCY  = 1,
    parameter bit         USE_BUS_WAIT = 1'b1
) (
    input  logic               clk,
    input  logic               reset_l,
    cga_vram_arbiter_if.slave  bus,
    output cga_state_e         state_dbg
);

    localparam logic [1:0] LAT_LAST = 2'(RAM_LATENCY - 1);

    cga_state_e        state, state_nxt;
    logic              rd_fall, wr_fall, rd_req, wr_req;
    logic              grant, cap_last;
    logic              wb_full, wr_wait, rd_pend, op_wr;
    logic [CPU_AW-1:0] wb_a, ww_a, rd_a;
    logic [7:0]        wb_d, ww_d, cpu_q_r;
    logic [1:0]        cap_cnt;

    cga_bus_sync u_memr_sync (.clk(clk), .reset_l(reset_l), .strobe_l(bus.cpu_memr_l), .fall(rd_fall));
    cga_bus_sync u_memw_sync (.clk(clk), .reset_l(reset_l), .strobe_l(bus.cpu_memw_l), .fall(wr_fall));

    assign rd_req   = rd_fall & bus.cpu_cs;
    assign wr_req   = wr_fall & bus.cpu_cs;
    assign grant    = (state == IDLE) && (bus.clk_seq == CPU_SLOT) && !bus.disp_req && (wb_full || rd_pend);
    assign cap_last = (cap_cnt == LAT_LAST);

    always_ff @(posedge clk) begin
        if (!reset_l) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant) state_nxt = ACCESS;
            ACCESS:  state_nxt = op_wr ? IDLE : CAPTURE;
            CAPTURE: if (cap_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ram_a    = bus.disp_addr;
        bus.ram_we_l = 1'b1;
        bus.ram_dout = '0;
        unique case (state)
            ACCESS: begin
                bus.ram_a    = op_wr ? {4'h0, wb_a} : {4'h0, rd_a};
                bus.ram_we_l = ~op_wr;
                if (op_wr) bus.ram_dout = wb_d;
            end
            CAPTURE: bus.ram_a = {4'h0, rd_a};
            default: ;
        endcase
    end

    // The buffered write always wins the grant, so a read queued behind it sees the new data.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            wb_full <= 1'b0;
            wb_a    <= '0;
            wb_d    <= '0;
            wr_wait <= 1'b0;
            ww_a    <= '0;
            ww_d    <= '0;
            rd_pend <= 1'b0;
            rd_a    <= '0;
            op_wr   <= 1'b0;
            cap_cnt <= '0;
            cpu_q_r <= '0;
        end else begin
            if (grant) op_wr <= wb_full;

            if (state == ACCESS && op_wr) begin
                wb_full <= 1'b0;
            end else if (wr_wait && !wb_full) begin
                wb_full <= 1'b1;
                wb_a    <= ww_a;
                wb_d    <= ww_d;
                wr_wait <= 1'b0;
            end else if (wr_req && !wb_full) begin
                wb_full <= 1'b1;
                wb_a    <= bus.cpu_a;
                wb_d    <= bus.cpu_d;
            end

            // A second write while the buffer is full is parked here and the bus is stalled.
            if (wr_req && wb_full && !wr_wait) begin
                wr_wait <= 1'b1;
                ww_a    <= bus.cpu_a;
                ww_d    <= bus.cpu_d;
            end

            if (rd_req && !rd_pend) begin
                rd_pend <= 1'b1;
                rd_a    <= bus.cpu_a;
            end else if (state == CAPTURE && cap_last) begin
                rd_pend <= 1'b0;
                cpu_q_r <= bus.ram_din;
            end

            cap_cnt <= (state == CAPTURE) ? cap_cnt + 2'd1 : 2'd0;
        end
    end

    assign bus.bus_rdy = USE_BUS_WAIT ? ~(rd_pend | wr_wait) : 1'b1;
    assign bus.cpu_q   = cpu_q_r;
    assign state_dbg   = state;

    // The sequencer must never fetch while the CPU holds the port.
    a_no_disp_during_cpu: assert property (@(posedge clk) disable iff (!reset_l)
        (state != IDLE) |-> !bus.disp_req);

    a_seq_in_range: assert property (@(posedge clk) disable iff (!reset_l)
        bus.clk_seq <= SEQ_MAX);

endmodule
